iir_coeff_scheduler: RTL

IIR_COEFF_SCHEDULER -- requirements
Module: iir_coeff_scheduler

---
 rtl/iir_coeff_scheduler.sv | 126 ++++++++++++
 1 files changed

// File: rtl/iir_coeff_scheduler.sv
// Double-buffered IIR coefficient store: writes land in a shadow bank, a commit
// arms a swap that happens on the next sample strobe, followed by a filter flush.
module iir_coeff_scheduler #(
  parameter int                     N            = 2,
  parameter int                     COEFF_WIDTH  = 16,
  parameter logic [COEFF_WIDTH-1:0] RESET_B0     = 16'h4000,
  parameter int                     FLUSH_CYCLES = 4,
  localparam int                    IDX_W        = $clog2(N+1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic                         wr_sel,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [COEFF_WIDTH-1:0]       wr_data,
  input  logic                         commit_valid,
  output logic                         commit_ready,
  input  logic                         sample_stb,
  output logic [COEFF_WIDTH*N-1:0]     packed_a_coeffs,
  output logic [COEFF_WIDTH*(N+1)-1:0] packed_b_coeffs,
  output logic                         filt_rst_n,
  output logic                         busy,
  output logic                         err_idx
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PENDING = 2'd1;
  localparam logic [1:0] FLUSH   = 2'd2;

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] flush_cnt;
  logic             err_q;
  logic             filt_rst_n_q;
  logic             wr_acc;
  logic             commit_acc;
  logic             wr_ok;
  logic             swap;

  logic signed [COEFF_WIDTH-1:0] shadow_a_p0 [N];
  logic signed [COEFF_WIDTH-1:0] shadow_b_p0 [N+1];
  logic signed [COEFF_WIDTH-1:0] active_a_p1 [N];
  logic signed [COEFF_WIDTH-1:0] active_b_p1 [N+1];

  // The a bank has one entry fewer than the b bank.
  function automatic logic idx_in_range(input logic sel, input logic [IDX_W-1:0] idx);
    if (sel) return (idx <= IDX_W'(N));
    else     return (idx <  IDX_W'(N));
  endfunction

  assign wr_ready     = (state == IDLE);
  assign commit_ready = (state == IDLE);
  assign busy         = (state != IDLE);
  assign err_idx      = err_q;
  assign filt_rst_n   = filt_rst_n_q;

  assign wr_acc     = wr_valid && wr_ready;
  assign commit_acc = commit_valid && commit_ready;
  assign wr_ok      = idx_in_range(wr_sel, wr_idx);
  assign swap       = (state == PENDING) && sample_stb;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (commit_acc) state_nxt = PENDING;
      PENDING: if (sample_stb) state_nxt = FLUSH;
      FLUSH:   if (flush_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: shadow bank capture; stage p1: active bank swap and control.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      flush_cnt    <= '0;
      err_q        <= 1'b0;
      filt_rst_n_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        shadow_a_p0[i] <= '0;
        active_a_p1[i] <= '0;
      end
      for (int i = 0; i <= N; i++) begin
        shadow_b_p0[i] <= (i == 0) ? RESET_B0 : '0;
        active_b_p1[i] <= (i == 0) ? RESET_B0 : '0;
      end
    end else begin
      state        <= state_nxt;
      filt_rst_n_q <= (state_nxt != FLUSH);

      if (wr_acc) begin
        for (int i = 0; i < N; i++)
          if (!wr_sel && wr_idx == IDX_W'(i)) shadow_a_p0[i] <= wr_data;
        for (int i = 0; i <= N; i++)
          if (wr_sel && wr_idx == IDX_W'(i)) shadow_b_p0[i] <= wr_data;
      end

      // A bad write in the commit cycle wins over the commit's clear.
      if (wr_acc && !wr_ok)
        err_q <= 1'b1;
      else if (commit_acc)
        err_q <= 1'b0;

      if (swap) begin
        for (int i = 0; i < N; i++)  active_a_p1[i] <= shadow_a_p0[i];
        for (int i = 0; i <= N; i++) active_b_p1[i] <= shadow_b_p0[i];
        flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
      end else if (state == FLUSH && flush_cnt != '0) begin
        flush_cnt <= flush_cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    packed_a_coeffs = '0;
    packed_b_coeffs = '0;
    for (int i = 0; i < N; i++)
      packed_a_coeffs[COEFF_WIDTH*i +: COEFF_WIDTH] = active_a_p1[i];
    for (int i = 0; i <= N; i++)
      packed_b_coeffs[COEFF_WIDTH*i +: COEFF_WIDTH] = active_b_p1[i];
  end

endmodule
